// File: rtl/kbd_ascii_controller.sv
// PS/2 set-2 scancode sequencer: prefix FSM, modifier tracking,
// one-deep lookup stage and a first-word fall-through character FIFO.
module kbd_ascii_controller #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_data,
    input  logic       kb_valid,
    output logic [7:0] lut_addr,
    output logic       lut_caps,
    input  logic [7:0] lut_data,
    output logic [7:0] asc_data,
    output logic       asc_valid,
    input  logic       asc_ready,
    output logic       capslock,
    output logic       shift_held,
    output logic       overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t state_q, state_d;
    logic lshift_q, lshift_d, rshift_q, rshift_d;
    logic caps_q, caps_d, held_q, held_d;
    logic issue;

    logic [7:0] lut_addr_q;
    logic       lut_caps_q, lk_vld_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          push, pop, full, push_ok;

    always_comb begin
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        held_d   = held_q;
        issue    = 1'b0;
        if (kb_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    unique case (kb_data)
                        8'hF0: state_d = S_BRK;
                        8'hE0: state_d = S_EXT;
                        8'h12: lshift_d = 1'b1;
                        8'h59: rshift_d = 1'b1;
                        8'h58: begin
                            // Held key repeats must not re-toggle
                            if (!held_q) caps_d = ~caps_q;
                            held_d = 1'b1;
                        end
                        default: issue = 1'b1;
                    endcase
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    unique case (kb_data)
                        8'h12:   lshift_d = 1'b0;
                        8'h59:   rshift_d = 1'b0;
                        8'h58:   held_d = 1'b0;
                        default: ;
                    endcase
                end
                S_EXT:     state_d = (kb_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
            held_q   <= held_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lut_addr_q <= 8'h00;
            lut_caps_q <= 1'b0;
            lk_vld_q   <= 1'b0;
        end else begin
            lk_vld_q <= issue;
            if (issue) begin
                lut_addr_q <= kb_data;
                lut_caps_q <= caps_q ^ (lshift_q | rshift_q);
            end
        end
    end

    assign push    = lk_vld_q && (lut_data != 8'h00);
    assign pop     = (count_q != '0) && asc_ready;
    assign full    = (count_q == CNT_FULL);
    // A pop frees the head slot this cycle, so a full FIFO can still accept
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= lut_data;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_ok && !pop)      count_q <= count_q + CNT_ONE;
            else if (!push_ok && pop) count_q <= count_q - CNT_ONE;
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    assign lut_addr   = lut_addr_q;
    assign lut_caps   = lut_caps_q;
    assign asc_valid  = (count_q != '0);
    assign asc_data   = asc_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign capslock   = caps_q;
    assign shift_held = lshift_q | rshift_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_kbd_ascii_controller.sv
// Directed bench for kbd_ascii_controller with a small behavioural
// scancode lookup table driven from lut_addr/lut_caps.
module tb_kbd_ascii_controller;
    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] kb_data;
    logic       kb_valid;
    logic [7:0] lut_addr;
    logic       lut_caps;
    logic [7:0] lut_data;
    logic [7:0] asc_data;
    logic       asc_valid;
    logic       asc_ready;
    logic       capslock;
    logic       shift_held;
    logic       overflow;
    logic [3:0] fifo_count;

    int n_chk  = 0;
    int n_fail = 0;

    kbd_ascii_controller #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .clrn(clrn),
        .kb_data(kb_data), .kb_valid(kb_valid),
        .lut_addr(lut_addr), .lut_caps(lut_caps), .lut_data(lut_data),
        .asc_data(asc_data), .asc_valid(asc_valid), .asc_ready(asc_ready),
        .capslock(capslock), .shift_held(shift_held),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        lut_data = 8'h00;
        case (lut_addr)
            8'h1C: lut_data = lut_caps ? 8'h41 : 8'h61;
            8'h16: lut_data = 8'h31;
            8'h1E: lut_data = 8'h32;
            8'h26: lut_data = 8'h33;
            8'h25: lut_data = 8'h34;
            8'h2E: lut_data = 8'h35;
            8'h36: lut_data = 8'h36;
            8'h3D: lut_data = 8'h37;
            8'h3E: lut_data = 8'h38;
            8'h46: lut_data = 8'h39;
            default: lut_data = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobes one byte over the next posedge.
    task automatic send(input logic [7:0] b);
        kb_data  = b;
        kb_valid = 1'b1;
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, {7'd0, asc_valid}, 8'h01);
        chk({tag, "_data"}, asc_data, exp);
        asc_ready = 1'b1;
        @(negedge clk);
        asc_ready = 1'b0;
    endtask

    logic [7:0] got [8];
    int n_got;
    logic [7:0] digits [9];

    initial begin
        digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                   8'h36, 8'h3D, 8'h3E, 8'h46};
        clrn = 1'b0; kb_data = 8'h00; kb_valid = 1'b0; asc_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {7'd0, asc_valid}, 8'h00);
        chk("rst_data", asc_data, 8'h00);
        chk("rst_addr", lut_addr, 8'h00);
        chk("rst_count", {4'd0, fifo_count}, 8'h00);
        chk("rst_caps", {7'd0, capslock}, 8'h00);
        chk("rst_ovf", {7'd0, overflow}, 8'h00);
        clrn = 1'b1;
        @(negedge clk);

        // Basic make + break
        send(8'h1C);
        chk("t1_addr", lut_addr, 8'h1C);
        chk("t1_early", {7'd0, asc_valid}, 8'h00);
        @(negedge clk);
        chk("t1_valid2", {7'd0, asc_valid}, 8'h01);
        send(8'hF0); send(8'h1C);
        repeat (2) @(negedge clk);
        chk("t1_count", {4'd0, fifo_count}, 8'h01);
        pop_expect("t1_char", 8'h61);
        chk("t1_empty", {7'd0, asc_valid}, 8'h00);
        chk("t1_edata", asc_data, 8'h00);

        // Caps lock, then shift inverting caps
        send(8'h58);
        chk("t2_caps", {7'd0, capslock}, 8'h01);
        send(8'hF0); send(8'h58);
        send(8'h1C);
        @(negedge clk);
        pop_expect("t2_A", 8'h41);
        send(8'h12);
        chk("t2_shift1", {7'd0, shift_held}, 8'h01);
        send(8'h1C);
        send(8'hF0); send(8'h12);
        chk("t2_shift0", {7'd0, shift_held}, 8'h00);
        send(8'h1C);
        @(negedge clk);
        pop_expect("t2_a", 8'h61);
        pop_expect("t2_A2", 8'h41);

        // Typematic caps: one toggle from 1 to 0
        send(8'h58);
        chk("t3_tog", {7'd0, capslock}, 8'h00);
        send(8'h58); send(8'h58);
        chk("t3_rep", {7'd0, capslock}, 8'h00);
        send(8'hF0); send(8'h58);
        chk("t3_brk", {7'd0, capslock}, 8'h00);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        repeat (2) @(negedge clk);
        chk("t3_noext", {4'd0, fifo_count}, 8'h00);
        send(8'h1C);
        @(negedge clk);
        pop_expect("t3_idle", 8'h61);

        // Back-to-back bytes with consumer always ready
        asc_ready = 1'b1;
        n_got = 0;
        fork
            begin
                send(8'h16); send(8'h1E); send(8'h26);
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    if (asc_valid && n_got < 8) begin
                        got[n_got] = asc_data;
                        n_got++;
                    end
                end
            end
        join
        asc_ready = 1'b0;
        chk("t4_n", 8'(n_got), 8'd3);
        chk("t4_c0", got[0], 8'h31);
        chk("t4_c1", got[1], 8'h32);
        chk("t4_c2", got[2], 8'h33);

        // Overflow: nine pushes into depth eight
        for (int i = 0; i < 9; i++) send(digits[i]);
        repeat (2) @(negedge clk);
        chk("t5_count", {4'd0, fifo_count}, 8'h08);
        chk("t5_ovf", {7'd0, overflow}, 8'h01);
        asc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_d%0d", i), asc_data, 8'h31 + 8'(i));
            @(negedge clk);
        end
        asc_ready = 1'b0;
        chk("t5_empty", {7'd0, asc_valid}, 8'h00);
        chk("t5_edata", asc_data, 8'h00);
        chk("t5_sticky", {7'd0, overflow}, 8'h01);

        // Reset between F0 and its break byte
        send(8'h58);
        send(8'hF0);
        clrn = 1'b0;
        #1;
        chk("t6_caps", {7'd0, capslock}, 8'h00);
        chk("t6_ovf", {7'd0, overflow}, 8'h00);
        chk("t6_count", {4'd0, fifo_count}, 8'h00);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        send(8'h1C);
        send(8'h58);
        chk("t6_held", {7'd0, capslock}, 8'h01);
        pop_expect("t6_char", 8'h61);
        chk("t6_after", {7'd0, asc_valid}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
